sr_pulse_stim: RTL and testbench

- Clocked stimulus-and-check stage that sits directly upstream of the sr_latch block.
- Generates programmable-width set and reset pulses on myset/myreset.
- Samples the latch's myoutQ/myoutNQ after each pulse through synchronizers and counts mismatches against the expected state.
- Used to characterise the latch (delay/IDM evaluation) with repeatable pulse trains.

---
 rtl/sr_stim_pkg.sv | 31 +++
 rtl/sr_pulse_stim_sync.sv | 24 ++
 rtl/sr_pulse_stim.sv | 188 ++++++++++++++++++
 tb/tb_sr_pulse_stim.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_stim_pkg.sv
// Shared state encodings, mode encodings and expected-state helper for sr_pulse_stim.
package sr_stim_pkg;

    localparam int unsigned ST_W   = 3;
    localparam int unsigned MODE_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_INIT  = 3'd1;
    localparam logic [ST_W-1:0] ST_PULSE = 3'd2;
    localparam logic [ST_W-1:0] ST_GAP   = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

    localparam logic [MODE_W-1:0] MODE_ALT  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_SET  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_RST  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;

    // Q a healthy latch settles to after pulse index (odd/even) in the given mode;
    // also selects which drive the pulse uses (1 = set, 0 = reset).
    function automatic logic exp_q_after(input logic [MODE_W-1:0] mode, input logic idx_odd);
        logic r;
        r = 1'b0;
        case (mode)
            MODE_ALT: r = ~idx_odd;
            MODE_SET: r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sr_pulse_stim_sync.sv
// Multi-flop synchroniser for a single asynchronous latch output.
module sr_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sr_pulse_stim.sv
// Programmable set/reset pulse generator and response checker for the sr_latch block.
module sr_pulse_stim
    import sr_stim_pkg::*;
#(
    parameter int unsigned PW_W        = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             myclk,
    input  logic             myrst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [PW_W-1:0]  pulse_len,
    input  logic [PW_W-1:0]  gap_len,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic             myoutQ,
    input  logic             myoutNQ,
    output logic             myset,
    output logic             myreset,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic             last_q,
    output logic             last_nq
);

    // Gap must outlast the synchroniser so the sample sees the settled latch.
    localparam logic [PW_W-1:0] G_MIN = PW_W'(SYNC_STAGES + 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [PW_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [PW_W-1:0]   p_q, p_d;
    logic [PW_W-1:0]   g_q, g_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic              expq_q, expq_d;
    logic              set_d, rst_d, busy_d, done_d;
    logic [CNT_W-1:0]  err_d;
    logic              lq_d, lnq_d;
    logic              sync_q, sync_nq;
    logic [PW_W-1:0]   p_in_c, g_in_c;
    logic              nxt_exp_c;
    logic              mismatch_c;

    sr_sync #(.STAGES(SYNC_STAGES)) u_sync_q (
        .clk   (myclk),
        .rst_n (myrst_n),
        .d     (myoutQ),
        .q     (sync_q)
    );

    sr_sync #(.STAGES(SYNC_STAGES)) u_sync_nq (
        .clk   (myclk),
        .rst_n (myrst_n),
        .d     (myoutNQ),
        .q     (sync_nq)
    );

    // Effective pulse/gap lengths from the live inputs, used at start capture.
    always_comb begin
        p_in_c = (pulse_len == '0) ? PW_W'(1) : pulse_len;
        g_in_c = (gap_len < G_MIN) ? G_MIN : gap_len;
    end

    // Expected state of the next pulse and mismatch of the current sample.
    always_comb begin
        nxt_exp_c  = exp_q_after(mode_q, idx_q[0]);
        mismatch_c = (sync_q != expq_q) || (sync_nq != ~expq_q);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        p_d     = p_q;
        g_d     = g_q;
        num_d   = num_q;
        expq_d  = expq_q;
        err_d   = err_count;
        lq_d    = last_q;
        lnq_d   = last_nq;
        set_d   = 1'b0;
        rst_d   = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                    mode_d  = mode;
                    p_d     = p_in_c;
                    g_d     = g_in_c;
                    num_d   = num_pulses;
                    cnt_d   = p_in_c - PW_W'(1);
                    idx_d   = '0;
                    err_d   = '0;
                    expq_d  = 1'b0;
                    rst_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_INIT, ST_PULSE: begin
                set_d = myset;
                rst_d = myreset;
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = g_q - PW_W'(1);
                    set_d   = 1'b0;
                    rst_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - PW_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    lq_d  = sync_q;
                    lnq_d = sync_nq;
                    if (mode_q != MODE_BOTH && mismatch_c && err_count != '1) begin
                        err_d = err_count + CNT_W'(1);
                    end
                    if (idx_q < num_q) begin
                        state_d = ST_PULSE;
                        cnt_d   = p_q - PW_W'(1);
                        idx_d   = idx_q + CNT_W'(1);
                        expq_d  = nxt_exp_c;
                        set_d   = (mode_q == MODE_BOTH) || nxt_exp_c;
                        rst_d   = (mode_q == MODE_BOTH) || !nxt_exp_c;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - PW_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, configuration and registered outputs.
    always_ff @(posedge myclk or negedge myrst_n) begin
        if (!myrst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            mode_q    <= '0;
            p_q       <= '0;
            g_q       <= '0;
            num_q     <= '0;
            expq_q    <= 1'b0;
            myset     <= 1'b0;
            myreset   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            last_q    <= 1'b0;
            last_nq   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            p_q       <= p_d;
            g_q       <= g_d;
            num_q     <= num_d;
            expq_q    <= expq_d;
            myset     <= set_d;
            myreset   <= rst_d;
            busy      <= busy_d;
            done      <= done_d;
            err_count <= err_d;
            last_q    <= lq_d;
            last_nq   <= lnq_d;
        end
    end

endmodule

// File: tb/tb_sr_pulse_stim.sv
// Self-checking bench for sr_pulse_stim with a behavioural latch and schedule model.
module tb_sr_pulse_stim;

    logic        myclk;
    logic        myrst_n;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  pulse_len;
    logic [7:0]  gap_len;
    logic [15:0] num_pulses;
    logic        myoutQ;
    logic        myoutNQ;
    logic        myset;
    logic        myreset;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic        last_q;
    logic        last_nq;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 0;
    bit stuck  = 0;

    sr_pulse_stim #(.PW_W(8), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .myclk      (myclk),
        .myrst_n    (myrst_n),
        .start      (start),
        .mode       (mode),
        .pulse_len  (pulse_len),
        .gap_len    (gap_len),
        .num_pulses (num_pulses),
        .myoutQ     (myoutQ),
        .myoutNQ    (myoutNQ),
        .myset      (myset),
        .myreset    (myreset),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count),
        .last_q     (last_q),
        .last_nq    (last_nq)
    );

    initial myclk = 1'b0;
    always #5 myclk = ~myclk;

    // Ideal NOR-style latch: set-only -> 1/0, reset-only -> 0/1, both -> 0/0, none -> hold.
    logic lat_q  = 1'b0;
    logic lat_nq = 1'b1;
    always @(myset or myreset) begin
        if (myset && !myreset) begin
            lat_q = 1'b1; lat_nq = 1'b0;
        end else if (!myset && myreset) begin
            lat_q = 1'b0; lat_nq = 1'b1;
        end else if (myset && myreset) begin
            lat_q = 1'b0; lat_nq = 1'b0;
        end
    end
    assign myoutQ  = stuck ? 1'b0 : lat_q;
    assign myoutNQ = lat_nq;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: per-cycle expectations derived from the pulse schedule arithmetic.
    bit          m_run;
    int          m_c, m_p, m_g, m_n, m_t, m_md;
    logic        e_set, e_rst, e_busy, e_done, e_lq, e_lnq;
    logic [15:0] e_err;

    // Pulse kind for schedule segment s: 0 reset, 1 set, 2 both.
    function automatic int kind(input int md, input int s);
        if (s == 0) return 0;
        case (md)
            0: return (((s - 1) % 2) == 0) ? 1 : 0;
            1: return 1;
            2: return 0;
            default: return 2;
        endcase
    endfunction

    always @(posedge myclk or negedge myrst_n) begin
        if (!myrst_n) begin
            m_run = 0; m_c = 0;
            e_set = 0; e_rst = 0; e_busy = 0; e_done = 0;
            e_err = '0; e_lq = 0; e_lnq = 0;
        end else begin
            bit prev_done;
            prev_done = e_done;
            e_done = 0;
            if (m_run) begin
                m_c++;
            end else if (start && !prev_done) begin
                m_md  = int'(mode);
                m_p   = (pulse_len == 0) ? 1 : int'(pulse_len);
                m_g   = (gap_len < 3) ? 3 : int'(gap_len);
                m_n   = int'(num_pulses);
                m_t   = (m_n + 1) * (m_p + m_g);
                m_run = 1; m_c = 1; e_err = '0;
            end
            if (m_run) begin
                int pg, s, k;
                logic oq, onq, xq;
                pg = m_p + m_g;
                if (m_c > 1 && ((m_c - 1) % pg) == 0) begin
                    s = (m_c - 1) / pg - 1;
                    k = kind(m_md, s);
                    oq  = (k == 1) ? !stuck : 1'b0;
                    onq = (k == 0);
                    xq  = (k == 1);
                    e_lq = oq; e_lnq = onq;
                    if (m_md != 3 && (oq != xq || onq != !xq) && e_err != 16'hFFFF) e_err = e_err + 16'd1;
                end
                if (m_c == m_t + 1) begin
                    e_set = 0; e_rst = 0; e_busy = 0; e_done = 1; m_run = 0;
                end else begin
                    e_busy = 1; e_set = 0; e_rst = 0;
                    if (((m_c - 1) % pg) < m_p) begin
                        k = kind(m_md, (m_c - 1) / pg);
                        e_set = (k != 0);
                        e_rst = (k != 1);
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model on the falling edge.
    always @(negedge myclk) begin
        if (cmp_en) begin
            chk("cycle_outputs",
                {myset, myreset, busy, done, err_count, last_q, last_nq},
                {e_set, e_rst, e_busy, e_done, e_err, e_lq, e_lnq});
        end
    end

    task automatic run(input logic [1:0] md, input int p, input int g, input int n, input bit stk,
                       input int x_lat, input int x_set, input int x_rst, input int x_err,
                       input logic x_lq, input logic x_lnq, input bit poke_busy, input bit poke_done);
        int lat, nset, nrst;
        bit seen;
        @(posedge myclk); #1;
        mode = md; pulse_len = 8'(p); gap_len = 8'(g); num_pulses = 16'(n); stuck = stk; start = 1'b1;
        @(posedge myclk); #1;
        start = 1'b0;
        mode = md ^ 2'b01; pulse_len = 8'd9; gap_len = 8'd9; num_pulses = 16'd7;
        lat = 1; nset = 0; nrst = 0; seen = 0;
        while (!seen && lat < 2000) begin
            if (done) begin
                seen = 1;
            end else begin
                nset += int'(myset);
                nrst += int'(myreset);
                start = (poke_busy && lat == 4);
                @(posedge myclk); #1;
                lat++;
            end
        end
        start = 1'b0;
        chk("done_latency", lat, x_lat);
        chk("set_cycles", nset, x_set);
        chk("reset_cycles", nrst, x_rst);
        chk("err_count", err_count, x_err);
        chk("last_q_nq", {last_q, last_nq}, {x_lq, x_lnq});
        if (poke_done) begin
            start = 1'b1;
            @(posedge myclk); #1;
            start = 1'b0;
            chk("start_in_done_ignored", {busy, myset, myreset}, 3'b000);
            @(posedge myclk); #1;
            chk("still_idle", {busy, myset, myreset}, 3'b000);
        end
    endtask

    initial begin
        myrst_n = 1'b0; start = 1'b0; mode = 2'b00;
        pulse_len = 8'd0; gap_len = 8'd0; num_pulses = 16'd0;
        repeat (3) @(posedge myclk);
        #1;
        chk("reset_state", {myset, myreset, busy, done, err_count, last_q, last_nq}, 22'd0);
        cmp_en = 1;
        myrst_n = 1'b1;

        run(2'b00, 3, 6, 4, 0, 46, 6, 9, 0, 1'b0, 1'b1, 0, 0);
        run(2'b01, 2, 4, 3, 1, 25, 6, 2, 3, 1'b0, 1'b0, 0, 0);
        run(2'b10, 0, 1, 2, 0, 13, 0, 3, 0, 1'b0, 1'b1, 0, 0);
        run(2'b11, 2, 4, 2, 0, 19, 4, 6, 0, 1'b0, 1'b0, 0, 0);

        // Abort a mode-00 run during its second pulse.
        @(posedge myclk); #1;
        mode = 2'b00; pulse_len = 8'd3; gap_len = 8'd6; num_pulses = 16'd4; stuck = 0; start = 1'b1;
        @(posedge myclk); #1;
        start = 1'b0;
        repeat (19) @(posedge myclk);
        #1;
        chk("second_pulse_drive", {myset, myreset, busy}, 3'b011);
        #2 myrst_n = 1'b0;
        #1;
        chk("async_abort", {myset, myreset, busy, done, err_count}, 20'd0);
        @(posedge myclk); #1;
        myrst_n = 1'b1;
        @(posedge myclk); #1;
        chk("idle_after_abort", {busy, done, myset, myreset}, 4'd0);

        run(2'b00, 2, 3, 1, 0, 11, 2, 2, 0, 1'b1, 1'b0, 1, 0);
        run(2'b00, 2, 3, 0, 0, 6, 0, 2, 0, 1'b0, 1'b1, 0, 1);

        repeat (2) @(posedge myclk);
        #1;
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
